// File: rtl/mem_access_ctrl_pkg.sv
// Shared sizing defaults and FSM state encoding for the data-RAM access sequencer.
package mem_access_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_LO  = 3'd1,
    WR_HI  = 3'd2,
    RD_LO  = 3'd3,
    RD_HI  = 3'd4,
    RD_CAP = 3'd5
  } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Sequences one narrow (nibble) or wide (byte) load/store at a time onto the
// synchronous 32x4 data RAM; loads return a registered one-cycle response.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_wide,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic [2*DATA_W-1:0]   rsp_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_read_address,
  output logic [ADDR_W-1:0]     mem_write_address,
  output logic [DATA_W-1:0]     mem_data_to_write,
  input  logic [DATA_W-1:0]     mem_data_read
);

  state_t              state;
  logic                wide_q;
  logic [DATA_W-1:0]   wdata_hi_q;
  logic [DATA_W-1:0]   rdata_lo_q;
  logic [ADDR_W-1:0]   mem_addr;
  logic [ADDR_W-1:0]   addr_inc;

  // Second nibble address; wraps 31 -> 0 by natural truncation.
  assign addr_inc          = mem_addr + ADDR_W'(1);
  assign mem_read_address  = mem_addr;
  assign mem_write_address = mem_addr;

  // NOTE: every output is registered and loaded on the edge that enters the
  // state it belongs to, so all state and outputs use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      req_ready         <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_rdata         <= '0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      mem_addr          <= '0;
      mem_data_to_write <= '0;
      wide_q            <= 1'b0;
      wdata_hi_q        <= '0;
      rdata_lo_q        <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            wide_q     <= req_wide;
            wdata_hi_q <= req_wdata[2*DATA_W-1:DATA_W];
            mem_addr   <= req_addr;
            if (req_write) begin
              state             <= WR_LO;
              mem_write         <= 1'b1;
              mem_data_to_write <= req_wdata[DATA_W-1:0];
            end else begin
              state    <= RD_LO;
              mem_read <= 1'b1;
            end
          end
        end
        WR_LO: begin
          if (wide_q) begin
            state             <= WR_HI;
            mem_addr          <= addr_inc;
            mem_data_to_write <= wdata_hi_q;
          end else begin
            state     <= IDLE;
            mem_write <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        WR_HI: begin
          state     <= IDLE;
          mem_write <= 1'b0;
          req_ready <= 1'b1;
        end
        RD_LO: begin
          if (wide_q) begin
            state    <= RD_HI;
            mem_addr <= addr_inc;
          end else begin
            state    <= RD_CAP;
            mem_read <= 1'b0;
          end
        end
        RD_HI: begin
          // Low nibble from the RD_LO read arrives now.
          rdata_lo_q <= mem_data_read;
          state      <= RD_CAP;
          mem_read   <= 1'b0;
        end
        RD_CAP: begin
          rsp_rdata <= wide_q ? {mem_data_read, rdata_lo_q}
                              : {{DATA_W{1'b0}}, mem_data_read};
          rsp_valid <= 1'b1;
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 32x4 synchronous RAM model and a
// queue-based response scoreboard checking data and latency.
module tb_mem_access_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_valid, req_ready, req_write, req_wide;
  logic [ADDR_W-1:0]   req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic                rsp_valid;
  logic [2*DATA_W-1:0] rsp_rdata;
  logic                mem_read, mem_write;
  logic [ADDR_W-1:0]   mem_read_address, mem_write_address;
  logic [DATA_W-1:0]   mem_data_to_write, mem_data_read;

  logic [DATA_W-1:0]   ram [32];

  typedef struct {
    logic [7:0] data;
    int         cyc;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   hs     = 0;
  bit   prev_rsp = 1'b0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_wide          (req_wide),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_data_to_write (mem_data_to_write),
    .mem_data_read     (mem_data_read)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, read data valid the cycle after mem_read.
  always @(posedge clk) begin
    if (mem_write) ram[mem_write_address] <= mem_data_to_write;
    if (mem_read)  mem_data_read <= ram[mem_read_address];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && req_valid && req_ready) hs <= hs + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor and protocol invariants.
  always @(negedge clk) begin
    if (mem_read || mem_write)
      check("rw_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
    if (rsp_valid) begin
      check("rsp_back_to_back", {31'b0, prev_rsp}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata 0x%0h with no load outstanding (cycle %0d)",
                 rsp_rdata, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({"data_", e.tag}, {24'b0, rsp_rdata}, {24'b0, e.data});
        check({"lat_", e.tag}, cyc, e.cyc);
      end
    end
    prev_rsp = rsp_valid;
  end

  // Drive a request from a negedge and wait for the accepting posedge.
  // hold=0 returns at the next negedge with req_valid dropped; hold=1 returns
  // right after the accept edge with the request still asserted.
  task automatic issue(input bit wr, input bit wide, input logic [4:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp_rd,
                       input string tag, input bit hold);
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_wide  = wide;
    req_addr  = addr;
    req_wdata = wd;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check({"accept_timeout_", tag}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (!wr) exp_q.push_back('{exp_rd, cyc + 1 + (wide ? 3 : 2), tag});
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", tag}, {31'b0, (exp_q.size() == 0) && req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    for (int i = 0; i < 32; i++) ram[i] = 4'(i * 3);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wide  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    #1;
    check("reset_outputs",
          {6'b0, req_ready, rsp_valid, rsp_rdata, mem_read, mem_write,
           mem_read_address, mem_write_address, mem_data_to_write}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", {31'b0, req_ready}, 32'd1);

    // 1. narrow store then narrow load at addr 5
    issue(1'b1, 1'b0, 5'd5, 8'h0A, 8'h00, "st5", 1'b0);
    @(negedge clk);
    check("st5_ram", {28'b0, ram[5]}, 32'hA);
    check("st5_ready_cycle2", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 1'b0, 5'd5, 8'h00, 8'h0A, "ld5", 1'b0);
    wait_idle("t1");

    // 2. wide store then wide load at addr 10
    issue(1'b1, 1'b1, 5'd10, 8'hC3, 8'h00, "st10", 1'b0);
    @(negedge clk);
    check("st10_busy_cycle2", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("st10_ready_cycle3", {31'b0, req_ready}, 32'd1);
    check("st10_ram_lo", {28'b0, ram[10]}, 32'h3);
    check("st10_ram_hi", {28'b0, ram[11]}, 32'hC);
    issue(1'b0, 1'b1, 5'd10, 8'h00, 8'hC3, "ld10", 1'b0);
    wait_idle("t2");

    // 3. wide access wrapping 31 -> 0, then narrow load of the wrapped nibble
    issue(1'b1, 1'b1, 5'd31, 8'h7E, 8'h00, "st31", 1'b0);
    wait_idle("t3a");
    check("st31_ram31", {28'b0, ram[31]}, 32'hE);
    check("st31_ram0", {28'b0, ram[0]}, 32'h7);
    issue(1'b0, 1'b1, 5'd31, 8'h00, 8'h7E, "ld31", 1'b0);
    issue(1'b0, 1'b0, 5'd0, 8'h00, 8'h07, "ld0", 1'b0);
    wait_idle("t3b");

    // 4. req_valid held high across a wide load; second request taken once
    hs0 = hs;
    issue(1'b0, 1'b1, 5'd10, 8'h00, 8'hC3, "ld10_hold", 1'b1);
    @(negedge clk);
    req_wide = 1'b0;
    req_addr = 5'd5;
    check("hold_busy_c1", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("hold_busy_c2", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("hold_busy_c3", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("hold_ready_c4", {31'b0, req_ready}, 32'd1);
    exp_q.push_back('{8'h0A, cyc + 3, "ld5_hold"});
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle("t4");
    check("hold_accept_count", hs - hs0, 32'd2);

    // 5. reset asserted during WR_HI of a wide store to addr 20
    issue(1'b1, 1'b1, 5'd20, 8'h12, 8'h00, "st20", 1'b0);
    @(negedge clk);
    check("st20_wr_hi_we", {31'b0, mem_write}, 32'd1);
    check("st20_wr_hi_addr", {27'b0, mem_write_address}, 32'd21);
    check("st20_wr_hi_data", {28'b0, mem_data_to_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("st20_reset_outputs",
          {6'b0, req_ready, rsp_valid, rsp_rdata, mem_read, mem_write,
           mem_read_address, mem_write_address, mem_data_to_write}, 32'd0);
    repeat (2) @(negedge clk);
    check("st20_ram_lo_written", {28'b0, ram[20]}, 32'h2);
    check("st20_ram_hi_untouched", {28'b0, ram[21]}, 32'hF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("st20_ready_after_reset", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 1'b1, 5'd20, 8'h00, 8'hF2, "ld20", 1'b0);
    wait_idle("t5");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
